// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sccb_pkg
// Brief    : Shared state encoding and constants for the SCCB responder.
// Revision : 1.0
// ============================================================================
package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID      = 3'd1,
        SUBADDR = 3'd2,
        DATA    = 3'd3,
        READ    = 3'd4,
        IGNORE  = 3'd5
    } sccb_state_e;

    localparam logic [3:0] SCCB_BIT_LAST = 4'd8;
    localparam logic [7:0] SCCB_READ_BIT = 8'h01;

    function automatic logic [7:0] sccb_read_id(input logic [7:0] write_id);
        return write_id | SCCB_READ_BIT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_slave_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : sccb_slave_responder_if
// Brief    : SCCB pad signals plus the register-side write/lookup port.
// Revision : 1.0
// ============================================================================
interface sccb_slave_responder_if;
    logic       SIOC;
    logic       SIOD_in;
    logic       SIOD_out;
    logic       SIOD_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  SIOC, SIOD_in, rd_data,
        output SIOD_out, SIOD_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
    );

    modport master (
        output SIOC, SIOD_in, rd_data,
        input  SIOD_out, SIOD_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/sccb_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : sccb_line_sync
// Brief    : SIOC/SIOD synchroniser with SIOC edge and start/stop detection.
// Revision : 1.0
// ============================================================================
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  sioc,
    input  wire  siod,
    output logic sioc_rise,
    output logic sioc_fall,
    output logic start_det,
    output logic stop_det,
    output logic siod_s
);

    logic [SYNC_STAGES-1:0] sioc_sync_q;
    logic [SYNC_STAGES-1:0] siod_sync_q;
    logic                   sioc_prev_q;
    logic                   siod_prev_q;
    logic                   sioc_s;

    // Flops reset to 1 to match an idle, pulled-up bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sioc_sync_q <= '1;
            siod_sync_q <= '1;
            sioc_prev_q <= 1'b1;
            siod_prev_q <= 1'b1;
        end else begin
            sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sioc};
            siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], siod};
            sioc_prev_q <= sioc_sync_q[SYNC_STAGES-1];
            siod_prev_q <= siod_sync_q[SYNC_STAGES-1];
        end
    end

    assign sioc_s    = sioc_sync_q[SYNC_STAGES-1];
    assign siod_s    = siod_sync_q[SYNC_STAGES-1];
    assign sioc_rise =  sioc_s & ~sioc_prev_q;
    assign sioc_fall = ~sioc_s &  sioc_prev_q;
    assign start_det =  sioc_s & sioc_prev_q &  siod_prev_q & ~siod_s;
    assign stop_det  =  sioc_s & sioc_prev_q & ~siod_prev_q &  siod_s;

endmodule
`default_nettype wire

// File: rtl/sccb_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : sccb_slave_responder
// Brief    : SCCB register target; 3-phase writes, 2-phase reads.
//            Define SCCB_ACK_DRIVE_EN to drive bit 8 low on matched phases.
// Revision : 1.0
// ============================================================================
module sccb_slave_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID   = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  wire                   clk,
    input  wire                   reset,
    sccb_slave_responder_if.slave bus
);

    logic        sioc_rise, sioc_fall, start_det, stop_det, siod_s;
    sccb_state_e state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  rx_q;
    logic [7:0]  tx_q;
    logic        out_q, oe_q, wr_valid_q, busy_q;
    logic [7:0]  wr_addr_q, wr_data_q, rd_addr_q;
    logic [7:0]  w_byte;
    logic        w_ack;

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .sioc      (bus.SIOC),
        .siod      (bus.SIOD_in),
        .sioc_rise (sioc_rise),
        .sioc_fall (sioc_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .siod_s    (siod_s)
    );

    assign w_byte = {rx_q[6:0], siod_s};

`ifdef SCCB_ACK_DRIVE_EN
    // rx_q holds the full ID byte once the counter has reached the NA bit.
    assign w_ack = (cnt_q == SCCB_BIT_LAST) &&
                   ((state_q == SUBADDR) || (state_q == DATA) ||
                    ((state_q == ID) && ((rx_q == DEVICE_ID) ||
                                         (rx_q == sccb_read_id(DEVICE_ID)))));
`else
    assign w_ack = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            out_q      <= 1'b1;
            oe_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            rd_addr_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            if (stop_det) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                oe_q    <= 1'b0;
                out_q   <= 1'b1;
                cnt_q   <= 4'd0;
            end else if (start_det) begin
                state_q <= ID;
                busy_q  <= 1'b1;
                oe_q    <= 1'b0;
                out_q   <= 1'b1;
                cnt_q   <= 4'd0;
            end else if (sioc_rise && (state_q inside {ID, SUBADDR, DATA, READ})) begin
                if (cnt_q < SCCB_BIT_LAST) rx_q <= w_byte;
                if (cnt_q == 4'd7) begin
                    if (state_q == SUBADDR) rd_addr_q <= w_byte;
                    if (state_q == DATA) begin
                        wr_addr_q  <= rd_addr_q;
                        wr_data_q  <= w_byte;
                        wr_valid_q <= 1'b1;
                    end
                end
                if (cnt_q == SCCB_BIT_LAST) begin
                    cnt_q <= 4'd0;
                    case (state_q)
                        ID: begin
                            if (rx_q == DEVICE_ID) begin
                                state_q <= SUBADDR;
                            end else if (rx_q == sccb_read_id(DEVICE_ID)) begin
                                state_q <= READ;
                                tx_q    <= bus.rd_data;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                        SUBADDR: state_q <= DATA;
                        default: state_q <= IGNORE;
                    endcase
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end else if (sioc_fall) begin
                if ((state_q == READ) && (cnt_q != SCCB_BIT_LAST)) begin
                    oe_q  <= 1'b1;
                    out_q <= tx_q[7];
                    tx_q  <= {tx_q[6:0], 1'b0};
                end else if (w_ack) begin
                    oe_q  <= 1'b1;
                    out_q <= 1'b0;
                end else begin
                    oe_q  <= 1'b0;
                    out_q <= 1'b1;
                end
            end
        end
    end

    assign bus.SIOD_out = out_q;
    assign bus.SIOD_oe  = oe_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_slave_responder
// Brief    : Directed bench driving an SCCB master against the responder.
// Revision : 1.0
// ============================================================================
module tb_sccb_slave_responder;

    localparam int Q = 5;
`ifdef SCCB_ACK_DRIVE_EN
    localparam logic ACK_LVL = 1'b0;
`else
    localparam logic ACK_LVL = 1'b1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic m_sioc = 1'b1;
    logic m_siod = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int wr_total = 0;
    int oe_total = 0;
    int busy_low_total = 0;
    logic [7:0] cap_addr = 8'h00;
    logic [7:0] cap_data = 8'h00;

    always #5 clk = ~clk;

    sccb_slave_responder_if bus();

    assign bus.SIOC    = m_sioc;
    assign bus.SIOD_in = m_siod & ~(bus.SIOD_oe & ~bus.SIOD_out);

    function automatic logic [7:0] regmap(input logic [7:0] a);
        case (a)
            8'h0A:   return 8'h76;
            8'h12:   return 8'h5C;
            default: return a ^ 8'hA5;
        endcase
    endfunction

    always_comb bus.rd_data = regmap(bus.rd_addr);

    sccb_slave_responder #(.DEVICE_ID(8'h42), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.wr_valid === 1'b1) begin
            wr_total = wr_total + 1;
            cap_addr = bus.wr_addr;
            cap_data = bus.wr_data;
        end
        if (bus.SIOD_oe === 1'b1) oe_total = oe_total + 1;
        if (bus.busy !== 1'b1) busy_low_total = busy_low_total + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_siod = 1'b1; tick(Q);
        m_sioc = 1'b1; tick(Q);
        m_siod = 1'b0; tick(Q);
        m_sioc = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_siod = 1'b0; tick(Q);
        m_sioc = 1'b1; tick(Q);
        m_siod = 1'b1; tick(2*Q);
    endtask

    task automatic bit_cycle(input logic b, output logic s, output logic oe);
        m_siod = b; tick(Q);
        m_sioc = 1'b1; tick(Q);
        s  = bus.SIOD_in;
        oe = bus.SIOD_oe;
        tick(Q);
        m_sioc = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s, oe;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s, oe);
        bit_cycle(1'b1, ack, oe);
    endtask

    task automatic read_byte(output logic [7:0] d, output logic oe_all, output logic na_oe);
        logic s, oe;
        oe_all = 1'b1;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, s, oe);
            d = {d[6:0], s};
            oe_all = oe_all & oe;
        end
        bit_cycle(1'b1, s, na_oe);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        n_cmp++; if (bus.SIOD_out !== 1'b1) begin n_err++; $display("FAIL reset_out: got %b want 1", bus.SIOD_out); end
        n_cmp++; if (bus.SIOD_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", bus.SIOD_oe); end
        n_cmp++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL reset_wr_valid: got %b want 0", bus.wr_valid); end
        n_cmp++; if (bus.wr_addr !== 8'h00) begin n_err++; $display("FAIL reset_wr_addr: got %h want 00", bus.wr_addr); end
        n_cmp++; if (bus.wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); end
        n_cmp++; if (bus.rd_addr !== 8'h00) begin n_err++; $display("FAIL reset_rd_addr: got %h want 00", bus.rd_addr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        reset = 1'b1;
        tick(4);
    endtask

    task automatic test_write();
        int w0;
        logic a0, a1, a2;
        w0 = wr_total;
        bus_start();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL write_busy_start: got %b want 1", bus.busy); end
        send_byte(8'h42, a0);
        send_byte(8'h12, a1);
        send_byte(8'h80, a2);
        bus_stop();
        n_cmp++; if (wr_total - w0 != 1) begin n_err++; $display("FAIL write_pulses: got %0d want 1", wr_total - w0); end
        n_cmp++; if (cap_addr !== 8'h12) begin n_err++; $display("FAIL write_addr: got %h want 12", cap_addr); end
        n_cmp++; if (cap_data !== 8'h80) begin n_err++; $display("FAIL write_data: got %h want 80", cap_data); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL write_busy_stop: got %b want 0", bus.busy); end
        n_cmp++; if ({a0, a1, a2} !== {3{ACK_LVL}}) begin n_err++; $display("FAIL write_na_level: got %b want %b", {a0, a1, a2}, {3{ACK_LVL}}); end
    endtask

    task automatic test_read();
        int w0;
        logic a, oe_all, na_oe;
        logic [7:0] d;
        bus_start(); send_byte(8'h42, a); send_byte(8'h0A, a); bus_stop();
        n_cmp++; if (bus.rd_addr !== 8'h0A) begin n_err++; $display("FAIL read_rd_addr: got %h want 0a", bus.rd_addr); end
        w0 = wr_total;
        bus_start();
        send_byte(8'h43, a);
        n_cmp++; if (a !== ACK_LVL) begin n_err++; $display("FAIL read_id_na: got %b want %b", a, ACK_LVL); end
        read_byte(d, oe_all, na_oe);
        bus_stop();
        n_cmp++; if (d !== 8'h76) begin n_err++; $display("FAIL read_data: got %h want 76", d); end
        n_cmp++; if (oe_all !== 1'b1) begin n_err++; $display("FAIL read_oe_bits: got %b want 1", oe_all); end
        n_cmp++; if (na_oe !== 1'b0) begin n_err++; $display("FAIL read_oe_na: got %b want 0", na_oe); end
        n_cmp++; if (wr_total != w0) begin n_err++; $display("FAIL read_no_write: got %0d want 0", wr_total - w0); end
    endtask

    task automatic test_wrong_id();
        int w0, o0;
        logic a0, a1, a2;
        w0 = wr_total; o0 = oe_total;
        bus_start(); send_byte(8'h60, a0); send_byte(8'h12, a1); send_byte(8'h55, a2); bus_stop();
        n_cmp++; if (wr_total != w0) begin n_err++; $display("FAIL wrongid_write: got %0d want 0", wr_total - w0); end
        n_cmp++; if (oe_total != o0) begin n_err++; $display("FAIL wrongid_oe: got %0d want 0", oe_total - o0); end
        n_cmp++; if (bus.rd_addr !== 8'h0A) begin n_err++; $display("FAIL wrongid_rd_addr: got %h want 0a", bus.rd_addr); end
        n_cmp++; if (a0 !== 1'b1) begin n_err++; $display("FAIL wrongid_na: got %b want 1", a0); end
    endtask

    task automatic test_abort();
        int w0;
        logic a, s, oe;
        w0 = wr_total;
        bus_start(); send_byte(8'h42, a); send_byte(8'h12, a);
        bit_cycle(1'b1, s, oe); bit_cycle(1'b0, s, oe);
        bit_cycle(1'b1, s, oe); bit_cycle(1'b0, s, oe);
        bus_stop();
        n_cmp++; if (wr_total != w0) begin n_err++; $display("FAIL abort_write: got %0d want 0", wr_total - w0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.wr_data !== 8'h80) begin n_err++; $display("FAIL abort_wr_data_held: got %h want 80", bus.wr_data); end
        bus_start(); send_byte(8'h42, a); send_byte(8'h13, a); send_byte(8'h01, a); bus_stop();
        n_cmp++; if (wr_total - w0 != 1) begin n_err++; $display("FAIL abort_next_pulses: got %0d want 1", wr_total - w0); end
        n_cmp++; if (cap_addr !== 8'h13) begin n_err++; $display("FAIL abort_next_addr: got %h want 13", cap_addr); end
        n_cmp++; if (cap_data !== 8'h01) begin n_err++; $display("FAIL abort_next_data: got %h want 01", cap_data); end
    endtask

    task automatic test_back_to_back();
        int w0, b0;
        logic a, oe_all, na_oe;
        logic [7:0] d;
        w0 = wr_total;
        bus_start();
        b0 = busy_low_total;
        send_byte(8'h42, a); send_byte(8'h12, a);
        bus_start();
        send_byte(8'h43, a);
        read_byte(d, oe_all, na_oe);
        n_cmp++; if (busy_low_total != b0) begin n_err++; $display("FAIL rstart_busy: got %0d low cycles want 0", busy_low_total - b0); end
        bus_stop();
        n_cmp++; if (d !== 8'h5C) begin n_err++; $display("FAIL rstart_data: got %h want 5c", d); end
        n_cmp++; if (wr_total != w0) begin n_err++; $display("FAIL rstart_write: got %0d want 0", wr_total - w0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstart_busy_stop: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_read();
        int w0;
        logic a, s, oe;
        // rd_addr is 0x12 here, so the read returns 0x5C = 0101_1100.
        bus_start(); send_byte(8'h43, a);
        bit_cycle(1'b1, s, oe); bit_cycle(1'b1, s, oe); bit_cycle(1'b1, s, oe);
        n_cmp++; if (bus.SIOD_oe !== 1'b1) begin n_err++; $display("FAIL midread_oe: got %b want 1", bus.SIOD_oe); end
        n_cmp++; if (bus.SIOD_out !== 1'b1) begin n_err++; $display("FAIL midread_out: got %b want 1", bus.SIOD_out); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.SIOD_oe !== 1'b0) begin n_err++; $display("FAIL arst_oe: got %b want 0", bus.SIOD_oe); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.SIOD_out !== 1'b1) begin n_err++; $display("FAIL arst_out: got %b want 1", bus.SIOD_out); end
        n_cmp++; if (bus.rd_addr !== 8'h00) begin n_err++; $display("FAIL arst_rd_addr: got %h want 00", bus.rd_addr); end
        m_sioc = 1'b1; m_siod = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(4);
        w0 = wr_total;
        bus_start(); send_byte(8'h42, a); send_byte(8'h21, a); send_byte(8'h3C, a); bus_stop();
        n_cmp++; if (wr_total - w0 != 1) begin n_err++; $display("FAIL arst_next_pulses: got %0d want 1", wr_total - w0); end
        n_cmp++; if ({cap_addr, cap_data} !== 16'h213C) begin n_err++; $display("FAIL arst_next_write: got %h want 213c", {cap_addr, cap_data}); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_id();
        test_abort();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
